// File: rtl/r5p_soc_memory_bist_if.sv
// tcb_lite_if: TCB-Lite point-to-point bus between one manager and one
// subordinate. Request (adr, wen, ren, byt, wdt) is qualified by vld and
// accepted on vld && rdy; the response (rdt, err) is valid DLY cycles later.
// Parameters: ADR address width, DAT data width, BYT byte-enable width,
// DLY read latency (>= 1), MOD transfer mode (1 = fixed-latency).
// Modports: man (drives request), sub (drives rdy and response).
interface tcb_lite_if #(
   parameter int unsigned ADR = 32,
   parameter int unsigned DAT = 32,
   parameter int unsigned BYT = DAT/8,
   parameter int unsigned DLY = 1,
   parameter int unsigned MOD = 1
) ();

   logic           vld;
   logic           rdy;
   logic           req_wen;
   logic           req_ren;
   logic [ADR-1:0] req_adr;
   logic [BYT-1:0] req_byt;
   logic [DAT-1:0] req_wdt;
   logic [DAT-1:0] rsp_rdt;
   logic           rsp_err;

   modport man (
      output vld, req_wen, req_ren, req_adr, req_byt, req_wdt,
      input  rdy, rsp_rdt, rsp_err
   );

   modport sub (
      input  vld, req_wen, req_ren, req_adr, req_byt, req_wdt,
      output rdy, rsp_rdt, rsp_err
   );

endinterface

// File: rtl/r5p_soc_memory_bist.sv
// r5p_soc_memory_bist: TCB-Lite manager that runs a 4-phase march test
// (write P, read/compare P, write ~P, read/compare ~P) over N words of a
// memory subordinate, P(i) = SEED ^ i.
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   start     pulse; starts a run when not busy
//   busy      run in progress (phases + drain)
//   done      run finished, held until the next accepted start
//   pass      done with zero failures
//   fail_cnt  failing reads (data mismatch or rsp_err), saturating
//   fail_adr  byte address of the first failing read, 0 if none
//   man       tcb_lite_if manager modport
// Parameters: BASE first byte address, SIZ tested bytes, SEED pattern seed,
// ADR width of fail_adr (must equal man.ADR).
// Build option: define R5P_SOC_MEMORY_BIST_STOP_EN to stop issuing on the
// first failure, drain, and freeze fail_cnt at 1.
module r5p_soc_memory_bist #(
   parameter logic [31:0]  BASE = 32'h0,
   parameter int unsigned  SIZ  = 4096,
   parameter logic [127:0] SEED = '0,
   parameter int unsigned  ADR  = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic [15:0]    fail_cnt,
   output logic [ADR-1:0] fail_adr,
   tcb_lite_if.man        man
);

   localparam int unsigned DAT = $bits(man.req_wdt);
   localparam int unsigned BYT = DAT/8;
   localparam int unsigned DLY = man.DLY;
   localparam int unsigned N   = SIZ/BYT;
   localparam int unsigned IW  = $clog2(N);
   // all compare stages except the oldest one
   localparam logic [DLY-1:0] TAIL = {DLY{1'b1}} >> 1;

   typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DRAIN, DONE} state_t;

   state_t         state;
   state_t         ph_nxt;
   logic [IW-1:0]  idx;
   logic [IW-1:0]  idx_inc;
   logic [DAT-1:0] pat_nxt;
   logic [ADR-1:0] adr_nxt;
   logic           xfer;
   logic           bad;
   logic           first_bad;
   logic [15:0]    fail_cnt_nxt;

   // compare line: stage DLY-1 lines up with rsp_rdt
   logic [DLY-1:0] p_vld;
   logic [ADR-1:0] p_adr [DLY];
   logic [DAT-1:0] p_exp [DLY];

`ifdef R5P_SOC_MEMORY_BIST_STOP_EN
   logic           stop;
`endif

   assign man.req_byt = '1;

   always_comb begin
      xfer    = man.vld && man.rdy;
      idx_inc = (idx == IW'(N-1)) ? '0 : idx + IW'(1);
      ph_nxt  = state;
      if (idx == IW'(N-1)) begin
         case (state)
            W0:      ph_nxt = R0;
            R0:      ph_nxt = W1;
            W1:      ph_nxt = R1;
            R1:      ph_nxt = DRAIN;
            default: ph_nxt = state;
         endcase
      end
      pat_nxt = DAT'(SEED) ^ DAT'(idx_inc);
      if (ph_nxt == W1 || ph_nxt == R1) pat_nxt = ~pat_nxt;
      adr_nxt = ADR'(BASE) + ADR'(idx_inc) * ADR'(BYT);

      bad       = p_vld[DLY-1] && ((man.rsp_rdt != p_exp[DLY-1]) || man.rsp_err);
      first_bad = bad && (fail_cnt == '0);
      fail_cnt_nxt = fail_cnt;
`ifdef R5P_SOC_MEMORY_BIST_STOP_EN
      if (first_bad) fail_cnt_nxt = 16'd1;
`else
      if (bad && fail_cnt != 16'hFFFF) fail_cnt_nxt = fail_cnt + 16'd1;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         idx         <= '0;
         man.vld     <= 1'b0;
         man.req_wen <= 1'b0;
         man.req_ren <= 1'b0;
         man.req_adr <= '0;
         man.req_wdt <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail_cnt    <= '0;
         fail_adr    <= '0;
         p_vld       <= '0;
         for (int unsigned k = 0; k < DLY; k++) begin
            p_adr[k] <= '0;
            p_exp[k] <= '0;
         end
`ifdef R5P_SOC_MEMORY_BIST_STOP_EN
         stop        <= 1'b0;
`endif
      end else begin
         // read requests carry the expected pattern on wdt
         p_vld[0] <= xfer && man.req_ren;
         p_adr[0] <= man.req_adr;
         p_exp[0] <= man.req_wdt;
         for (int unsigned k = 1; k < DLY; k++) begin
            p_vld[k] <= p_vld[k-1];
            p_adr[k] <= p_adr[k-1];
            p_exp[k] <= p_exp[k-1];
         end

         fail_cnt <= fail_cnt_nxt;
         if (first_bad) fail_adr <= p_adr[DLY-1];

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= W0;
                  idx         <= '0;
                  man.vld     <= 1'b1;
                  man.req_wen <= 1'b1;
                  man.req_ren <= 1'b0;
                  man.req_adr <= ADR'(BASE);
                  man.req_wdt <= DAT'(SEED);
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  fail_cnt    <= '0;
                  fail_adr    <= '0;
`ifdef R5P_SOC_MEMORY_BIST_STOP_EN
                  stop        <= 1'b0;
`endif
               end
            end
            W0, R0, W1, R1: begin
`ifdef R5P_SOC_MEMORY_BIST_STOP_EN
               // a stalled request must still complete before vld drops
               if (stop || first_bad) begin
                  if (man.vld && !man.rdy) begin
                     stop <= 1'b1;
                  end else begin
                     man.vld <= 1'b0;
                     state   <= DRAIN;
                  end
               end else
`endif
               if (xfer) begin
                  idx <= idx_inc;
                  if (ph_nxt == DRAIN) begin
                     man.vld     <= 1'b0;
                     man.req_ren <= 1'b0;
                     state       <= DRAIN;
                  end else begin
                     state       <= ph_nxt;
                     man.req_wen <= (ph_nxt == W0) || (ph_nxt == W1);
                     man.req_ren <= (ph_nxt == R0) || (ph_nxt == R1);
                     man.req_adr <= adr_nxt;
                     man.req_wdt <= pat_nxt;
                  end
               end
            end
            DRAIN: begin
               // leave once the oldest entry is checked this cycle
               if ((p_vld & TAIL) == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (fail_cnt_nxt == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_r5p_soc_memory_bist.sv
module tb_r5p_soc_memory_bist;

   localparam logic [31:0] BASE = 32'h100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] fail_cnt;
   logic [31:0] fail_adr;

   tcb_lite_if #(.ADR(32), .DAT(32), .BYT(4), .DLY(1), .MOD(1)) bus ();

   r5p_soc_memory_bist #(
      .BASE (BASE),
      .SIZ  (64),
      .SEED ('0),
      .ADR  (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .fail_cnt (fail_cnt),
      .fail_adr (fail_adr),
      .man      (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // memory model, DLY=1, with read fault masks
   logic [31:0] mem   [16];
   logic [31:0] and_m [16];
   logic [31:0] xor_m [16];
   int   xfer_cnt, seq_err, stab_err, vld_cyc, wr_after_rd, err_at;
   bit   seen_rd, stalled, rnd_rdy;
   logic [31:0] s_adr, s_wdt, off, iv;
   logic        s_wen, s_ren;
   logic [3:0]  widx;
   int          ph, ii;

   always @(negedge clk) bus.rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

   always @(posedge clk) begin
      if (stalled && (!bus.vld || bus.req_adr != s_adr || bus.req_wdt != s_wdt ||
                      bus.req_wen != s_wen || bus.req_ren != s_ren))
         stab_err++;
      if (bus.vld) vld_cyc++;
      if (bus.vld && bus.rdy) begin
         off  = bus.req_adr - BASE;
         widx = off[5:2];
         ph   = xfer_cnt / 16;
         ii   = xfer_cnt % 16;
         iv   = 32'(ii);
         if (xfer_cnt >= 64) seq_err++;
         else begin
            if (bus.req_adr != BASE + 32'(4*ii)) seq_err++;
            if (bus.req_wen != (ph % 2 == 0)) seq_err++;
            if (bus.req_ren == bus.req_wen) seq_err++;
            if (bus.req_byt != 4'hF) seq_err++;
            if (bus.req_wen && bus.req_wdt != ((ph >= 2) ? ~iv : iv)) seq_err++;
         end
         if (bus.req_wen) begin
            mem[widx] <= bus.req_wdt;
            if (seen_rd) wr_after_rd++;
         end
         if (bus.req_ren) seen_rd = 1'b1;
         bus.rsp_rdt <= (mem[widx] & and_m[widx]) ^ xor_m[widx];
         bus.rsp_err <= bus.req_ren && (xfer_cnt == err_at);
         xfer_cnt++;
      end else begin
         bus.rsp_err <= 1'b0;
      end
      stalled = bus.vld && !bus.rdy;
      s_adr = bus.req_adr; s_wdt = bus.req_wdt;
      s_wen = bus.req_wen; s_ren = bus.req_ren;
   end

   task automatic clr();
      xfer_cnt = 0; seq_err = 0; stab_err = 0; vld_cyc = 0;
      wr_after_rd = 0; seen_rd = 1'b0; stalled = 1'b0; err_at = -1;
      for (int i = 0; i < 16; i++) begin
         and_m[i] = '1;
         xor_m[i] = '0;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(tag, done, 1'b1);
   endtask

   task automatic check_clean(input string tag);
      check({tag, "_xfer"}, xfer_cnt, 64);
      check({tag, "_seq"}, seq_err, 0);
      check({tag, "_stab"}, stab_err, 0);
      check({tag, "_pass"}, pass, 1'b1);
      check({tag, "_cnt"}, fail_cnt, 0);
      check({tag, "_adr"}, fail_adr, 0);
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      rnd_rdy = 1'b0;
      bus.rdy = 1'b1;
      bus.rsp_rdt = '0;
      bus.rsp_err = 1'b0;
      clr();
      repeat (3) @(negedge clk);
      check("rst_vld", bus.vld, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_pass", pass, 1'b0);
      check("rst_cnt", fail_cnt, 0);
      check("rst_adr", fail_adr, 0);
      rst = 1'b1;

      // clean run, rdy always high
      @(negedge clk) clr();
      pulse_start();
      check("t1_busy", busy, 1'b1);
      check("t1_vld", bus.vld, 1'b1);
      wait_done("t1_done");
      check_clean("t1");
      check("t1_vldcyc", vld_cyc, 64);
      repeat (5) @(negedge clk);
      check("t1_hold_done", done, 1'b1);
      check("t1_hold_pass", pass, 1'b1);

      // random rdy, plus a start pulse while busy that must be ignored
      @(negedge clk) clr();
      rnd_rdy = 1'b1;
      pulse_start();
      repeat (20) @(negedge clk);
      check("t2_busy_mid", busy, 1'b1);
      pulse_start();
      wait_done("t2_done");
      rnd_rdy = 1'b0;
      check_clean("t2");

      // bit3 of word 5 stuck at 0: R0 clean, R1 fails
      @(negedge clk) clr();
      and_m[5] = ~32'h8;
      pulse_start();
      for (int n = 0; n < 500 && xfer_cnt < 33; n++) @(negedge clk);
      check("t3_r0_cnt", fail_cnt, 0);
      wait_done("t3_done");
      check("t3_cnt", fail_cnt, 1);
      check("t3_adr", fail_adr, BASE + 32'd20);
      check("t3_pass", pass, 1'b0);
      check("t3_xfer", xfer_cnt, 64);

      // start from DONE clears results
      @(negedge clk) clr();
      pulse_start();
      check("t4_cnt_clr", fail_cnt, 0);
      check("t4_adr_clr", fail_adr, 0);
      check("t4_done_clr", done, 1'b0);
      check("t4_busy", busy, 1'b1);
      wait_done("t4_done");
      check_clean("t4");

      // error response on third R0 read
      @(negedge clk) clr();
      err_at = 18;
      pulse_start();
      wait_done("t5_done");
      check("t5_cnt", fail_cnt, 1);
      check("t5_adr", fail_adr, BASE + 32'd8);
      check("t5_pass", pass, 1'b0);

      // reset while R0 at i=7 is on the bus
      @(negedge clk) clr();
      pulse_start();
      for (int n = 0; n < 500 && xfer_cnt < 23; n++) @(negedge clk);
      check("t6_at", xfer_cnt, 23);
      check("t6_ren", bus.req_ren, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("t6_vld", bus.vld, 1'b0);
      check("t6_busy", busy, 1'b0);
      check("t6_done", done, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk) clr();
      pulse_start();
      wait_done("t6b_done");
      check_clean("t6b");

      // data faults at words 2 and 9
      @(negedge clk) clr();
      xor_m[2] = 32'h1;
      xor_m[9] = 32'h1;
      pulse_start();
      wait_done("t7_done");
      check("t7_adr", fail_adr, BASE + 32'd8);
      check("t7_pass", pass, 1'b0);
`ifdef R5P_SOC_MEMORY_BIST_STOP_EN
      check("t7_cnt", fail_cnt, 1);
      check("t7_w1", wr_after_rd, 0);
      check("t7_xfer", xfer_cnt, 20);
`else
      check("t7_cnt", fail_cnt, 4);
      check("t7_xfer", xfer_cnt, 64);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
